fan_pwm_driver: RTL and testbench
=================================

# fan_pwm_driver

Motor-side consumer of the fan control panel's wind-level output. It samples the 7-bit thermometer LED code (0 to 7 lit segments) and decodes it into a target speed level. It ramps the applied level toward that target one step at a time, on PWM-period boundaries, and drives a glitch-free PWM signal to the fan motor stage. Invalid codes are flagged and ignored.

## Interface
- `STEP`, default 10: PWM cycles per speed level. PWM period = 7*STEP clock cycles.
- `RAMP_PERIODS`, default 2: number of PWM-period boundaries between successive one-level ramp steps (≥1).
- `clk` in, 1: system clock.
- `rst` in, 1: asynchronous, active-high reset.
- `led` in, 7: thermometer wind code from the control panel. Valid values are 0000000, 0000001, 0000011, …, 1111111.
- `pwm` out, 1: registered motor drive.
- `level` out, 3: level currently applied to the PWM (0–7).
- `busy` out, 1: high while `level` ≠ target.
- `fault` out, 1: high while the sampled `led` code is not a valid thermometer code.

## Operation
- Input stage: `led_q` <= `led` every cycle.
- Decode stage:
  - Valid `led_q` → `target` <= popcount, `fault` <= 0.
  - Invalid `led_q` → `target` holds its last valid value, `fault` <= 1.
  - `fault` is not sticky.
- PWM counter `cnt` runs 0 … 7*STEP−1 and wraps. A "boundary" is a cycle with `cnt` = 7*STEP−1.
- `pwm` <= (`cnt` < `level`*STEP).
  - Level 0 → constant 0.
  - Level 7 → constant 1.
  - Level n → exactly n*STEP high cycles per period.
- Ramp FSM states: IDLE, RAMP_UP, RAMP_DOWN, HOLD.
  - IDLE (`level` = 0): `target` > 0 → RAMP_UP.
  - RAMP_UP / RAMP_DOWN: at each boundary `ramp_cnt` increments. When `ramp_cnt` = RAMP_PERIODS−1 at a boundary, `level` moves ±1 and `ramp_cnt` <= 0. When `level` reaches `target`, the FSM goes to HOLD.
  - HOLD: `target` > `level` → RAMP_UP; 0 < `target` < `level` → RAMP_DOWN.
  - Any state: `target` = 0 → `level` <= 0 on the next edge, not boundary-aligned, as a safety stop. `ramp_cnt` <= 0, FSM goes to IDLE.
- Any cycle in which `target` changes clears `ramp_cnt`. A direction reversal mid-ramp restarts the step spacing.
- `level` changes only at boundaries, except on a stop. Each PWM period is therefore generated with a single duty.
- `busy` = (`level` ≠ `target`).

## Timing
- Reset values: `pwm` 0, `level` 0, `busy` 0, `fault` 0, `led_q` 0, `target` 0, `cnt` 0, `ramp_cnt` 0, FSM in IDLE. Reset is asynchronous and takes effect mid-period.
- `led` → `target` / `fault`: 2 cycles.
- Stop path: `led` → 0000000 gives `level` = 0 after 3 edges and `pwm` low after 4 edges.
- Ramp step spacing is RAMP_PERIODS*7*STEP cycles. The first step comes at the RAMP_PERIODS-th boundary after `target` changes.
- `pwm` lags `cnt` by 1 cycle. The new duty applies to the whole period that follows the stepping boundary.
- A `target` change in the same cycle as a boundary step: the ramp step is suppressed, `ramp_cnt` <= 0, and direction is re-evaluated.
- Full 0→7 ramp: 7*RAMP_PERIODS periods (980 cycles at defaults).

## Structure
- Package `fan_pkg`:
  - `level_t` (3-bit).
  - FSM state enum.
  - `THERM_CODE[0:7]` constants, shared with the panel encoder.
  - Function `therm2level` returning level plus valid flag.
- Sub-module `fan_pwm_gen` contains the `cnt` counter, the boundary strobe and the registered compare, parameterized by `STEP`.
- The top level holds the input/decode registers, the ramp FSM and `ramp_cnt`.

## Test plan
All scenarios use STEP=10, RAMP_PERIODS=2, period 70.
- Reset: assert `rst` mid-period at level 4 → all outputs 0 immediately. After release, `pwm` stays 0.
- `led` 0000000→0000111 → `target` 3 after 2 cycles, `busy` 1.
  - `level` is 1, 2, 3 at the 2nd, 4th and 6th boundaries; then `busy` 0.
  - Steady `pwm` is 30 high / 40 low.
- `led` 1111111 held until settled → `level` 7, `pwm` constantly 1, and no low glitch across wraps.
- From level 5, `led` → 0000000 → `level` 0 on the 3rd edge and `pwm` 0 on the 4th, both mid-period; FSM IDLE.
- `led` = 0000101 at level 3 → `fault` 1 after 2 cycles, `target` and `level` stay 3. Returning to 0000011 clears `fault` after 2 cycles.
- Target 7 from 0; at `level` 4 switch `led` to 0000011 → `ramp_cnt` clears, `level` goes 3 then 2 at 2-boundary spacing, then HOLD.

Source files
------------

// File: rtl/fan_pkg.sv
// Shared types and constants for the fan motor PWM driver and the panel encoder.
package fan_pkg;

    typedef logic [2:0] level_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2,
        HOLD      = 2'd3
    } ramp_state_t;

    localparam int LED_W      = 7;
    localparam int NUM_LEVELS = 8;

    // Thermometer code for each wind level; index = number of lit segments.
    localparam logic [LED_W-1:0] THERM_CODE [0:NUM_LEVELS-1] = '{
        7'b0000000,
        7'b0000001,
        7'b0000011,
        7'b0000111,
        7'b0001111,
        7'b0011111,
        7'b0111111,
        7'b1111111
    };

    typedef struct packed {
        level_t level;
        logic   valid;
    } therm_dec_t;

    // Decode a thermometer code; anything not in the table is reported invalid.
    function automatic therm_dec_t therm2level(input logic [LED_W-1:0] code);
        therm_dec_t res;
        res.level = '0;
        res.valid = 1'b0;
        for (int i = 0; i < NUM_LEVELS; i++) begin
            if (code == THERM_CODE[i]) begin
                res.level = level_t'(i);
                res.valid = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fan_pwm_gen.sv
// PWM period counter, end-of-period strobe and registered duty compare.
module fan_pwm_gen
    import fan_pkg::*;
#(
    parameter int STEP = 10
) (
    input  logic   clk,
    input  logic   rst,
    input  level_t level,
    output logic   boundary,
    output logic   pwm
);

    localparam int PERIOD = 7 * STEP;
    localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pwm_q, pwm_d;

    // Next counter value and duty compare; level is only updated at a
    // boundary, so each period is compared against a single level.
    always_comb begin
        // NOTE: every signal written here gets a value on every path first,
        // otherwise synthesis infers a latch to hold the old value.
        cnt_d    = cnt_q + 1'b1;
        boundary = (cnt_q == CNT_W'(PERIOD - 1));
        if (boundary) begin
            cnt_d = '0;
        end
        pwm_d = (int'(cnt_q) < int'(level) * STEP);
    end

    // Counter and registered PWM output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: state uses non-blocking assignments so every flop samples
            // pre-edge values regardless of statement order.
            cnt_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pwm_q <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/fan_pwm_driver.sv
// Samples the panel's thermometer code, ramps the applied level toward the
// decoded target one step per RAMP_PERIODS PWM periods, and drives the PWM.
module fan_pwm_driver
    import fan_pkg::*;
#(
    parameter int STEP         = 10,
    parameter int RAMP_PERIODS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LED_W-1:0] led,
    output logic             pwm,
    output logic [2:0]       level,
    output logic             busy,
    output logic             fault
);

    localparam int RC_W = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;

    logic [LED_W-1:0] led_q;
    level_t           target_q, target_d;
    logic             fault_q, fault_d;
    logic             target_chg;
    therm_dec_t       dec;

    level_t           level_q, level_d;
    logic [RC_W-1:0]  ramp_cnt_q, ramp_cnt_d;
    ramp_state_t      state_q, state_d;
    logic             boundary;
    logic             tick;

    // Where the applied level stands relative to the target.
    function automatic ramp_state_t dir_state(input level_t lvl, input level_t tgt);
        if (tgt > lvl) begin
            return RAMP_UP;
        end else if (tgt < lvl) begin
            return RAMP_DOWN;
        end
        return HOLD;
    endfunction

    // Decode the sampled code; an invalid code keeps the last good target.
    always_comb begin
        dec        = therm2level(led_q);
        target_d   = dec.valid ? dec.level : target_q;
        fault_d    = ~dec.valid;
        target_chg = (target_d != target_q);
    end

    // Ramp FSM: step spacing counter, level update and next state.
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        ramp_cnt_d = ramp_cnt_q;
        // A target update landing on a boundary suppresses that step.
        tick       = boundary && !target_chg;

        if ((target_q != level_q) && tick) begin
            if (ramp_cnt_q == RC_W'(RAMP_PERIODS - 1)) begin
                ramp_cnt_d = '0;
                level_d    = (target_q > level_q) ? level_q + 1'b1 : level_q - 1'b1;
            end else begin
                ramp_cnt_d = ramp_cnt_q + 1'b1;
            end
        end

        // A new target restarts the step spacing from zero.
        if (target_chg) begin
            ramp_cnt_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (target_q != '0) begin
                    state_d = dir_state(level_d, target_q);
                end
            end
            RAMP_UP, RAMP_DOWN, HOLD: begin
                // Reaching the target holds; a reversed target flips direction.
                state_d = dir_state(level_d, target_q);
            end
            default: state_d = IDLE;
        endcase

        // Safety stop: zero target drops the level at once, off-boundary.
        if (target_q == '0) begin
            level_d    = '0;
            ramp_cnt_d = '0;
            state_d    = IDLE;
        end
    end

    // Input sample, decode and ramp registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q      <= '0;
            target_q   <= '0;
            fault_q    <= 1'b0;
            level_q    <= '0;
            ramp_cnt_q <= '0;
            state_q    <= IDLE;
        end else begin
            led_q      <= led;
            target_q   <= target_d;
            fault_q    <= fault_d;
            level_q    <= level_d;
            ramp_cnt_q <= ramp_cnt_d;
            state_q    <= state_d;
        end
    end

    fan_pwm_gen #(
        .STEP (STEP)
    ) u_pwm_gen (
        .clk      (clk),
        .rst      (rst),
        .level    (level_q),
        .boundary (boundary),
        .pwm      (pwm)
    );

    assign level = level_q;
    assign busy  = (level_q != target_q);
    assign fault = fault_q;

endmodule

// File: tb/tb_fan_pwm_driver.sv
// Scoreboard bench: expectations are queued against the edge count since
// reset release and compared on the falling edge when that edge is reached.
module tb_fan_pwm_driver;
    import fan_pkg::*;

    localparam int STEP = 10;
    localparam int RP   = 2;
    localparam int PER  = 7 * STEP;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] led = '0;
    logic       pwm;
    logic [2:0] level;
    logic       busy;
    logic       fault;

    int total = 0;
    int bad   = 0;
    int ecnt  = 0;

    typedef enum int {SIG_PWM, SIG_LEVEL, SIG_BUSY, SIG_FAULT, SIG_TARGET, SIG_STATE, SIG_RCNT} sig_e;

    typedef struct {
        int    at;
        sig_e  sig;
        int    val;
        string tag;
    } exp_t;

    exp_t sb[$];

    fan_pwm_driver #(
        .STEP         (STEP),
        .RAMP_PERIODS (RP)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .led   (led),
        .pwm   (pwm),
        .level (level),
        .busy  (busy),
        .fault (fault)
    );

    always #5 clk = ~clk;

    // Edges since reset release; after edge k the PWM counter sits at k mod PER.
    always @(posedge clk or posedge rst) begin
        if (rst) ecnt <= 0;
        else     ecnt <= ecnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, act, exp, ecnt);
        end
    endtask

    task automatic push(input int at, input sig_e s, input int val, input string tag);
        exp_t e;
        e.at  = at;
        e.sig = s;
        e.val = val;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Expected PWM after edge k: the compare used counter value (k-1) mod PER.
    task automatic push_pwm(input int from, input int to, input int lvl, input string tag);
        for (int k = from; k <= to; k++) begin
            push(k, SIG_PWM, (((k - 1) % PER) < lvl * STEP) ? 1 : 0, tag);
        end
    endtask

    function automatic logic [31:0] sample(input sig_e s);
        case (s)
            SIG_PWM:    return 32'(pwm);
            SIG_LEVEL:  return 32'(level);
            SIG_BUSY:   return 32'(busy);
            SIG_FAULT:  return 32'(fault);
            SIG_TARGET: return 32'(dut.target_q);
            SIG_STATE:  return 32'(dut.state_q);
            SIG_RCNT:   return 32'(dut.ramp_cnt_q);
            default:    return '1;
        endcase
    endfunction

    // Scoreboard: pop every expectation due at this edge and compare it.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].at <= ecnt) begin
                    if (sb[i].at < ecnt) check({sb[i].tag, "_late"}, ecnt, sb[i].at);
                    else                 check(sb[i].tag, sample(sb[i].sig), sb[i].val);
                    sb.delete(i);
                end
            end
        end
    end

    task automatic goto(input int n);
        while (ecnt < n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", ecnt);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        led = '0;
        repeat (3) @(negedge clk);
        check("rst_pwm", pwm, 0);
        check("rst_level", level, 0);
        check("rst_busy", busy, 0);
        check("rst_fault", fault, 0);
        rst = 1'b0;

        // 0 -> 3: target after 2 edges, steps at boundaries 2, 4, 6.
        goto(5);
        led = 7'b0000111;
        push(6, SIG_TARGET, 0, "tgt_lat1");
        push(6, SIG_BUSY, 0, "busy_lat1");
        push(7, SIG_TARGET, 3, "tgt_3");
        push(7, SIG_BUSY, 1, "busy_up");
        push(139, SIG_LEVEL, 0, "lvl_pre1");
        push(140, SIG_LEVEL, 1, "lvl_1");
        push(279, SIG_LEVEL, 1, "lvl_pre2");
        push(280, SIG_LEVEL, 2, "lvl_2");
        push(419, SIG_LEVEL, 2, "lvl_pre3");
        push(419, SIG_BUSY, 1, "busy_pre3");
        push(420, SIG_LEVEL, 3, "lvl_3");
        push(420, SIG_BUSY, 0, "busy_done3");
        push(420, SIG_STATE, int'(HOLD), "state_hold3");
        push_pwm(421, 490, 3, "pwm_l3");

        // Invalid code: fault only, target and level stay.
        goto(500);
        led = 7'b0000101;
        push(501, SIG_FAULT, 0, "fault_lat1");
        push(502, SIG_FAULT, 1, "fault_set");
        push(502, SIG_TARGET, 3, "fault_tgt");
        push(640, SIG_LEVEL, 3, "fault_lvl");
        push(640, SIG_BUSY, 0, "fault_busy");
        goto(650);
        led = 7'b0000011;
        push(651, SIG_FAULT, 1, "fault_hold");
        push(652, SIG_FAULT, 0, "fault_clr");
        push(652, SIG_TARGET, 2, "tgt_2");
        push(769, SIG_LEVEL, 3, "dn_pre2");
        push(770, SIG_LEVEL, 2, "dn_2");
        push(770, SIG_BUSY, 0, "dn_busy");

        // Full scale: level 7 gives a constant-high PWM across wraps.
        goto(800);
        led = 7'b1111111;
        push(802, SIG_TARGET, 7, "tgt_7");
        for (int i = 0; i < 5; i++) begin
            push(909 + 140 * i, SIG_LEVEL, 2 + i, "up7_pre");
            push(910 + 140 * i, SIG_LEVEL, 3 + i, "up7_step");
        end
        push_pwm(1401, 1470, 6, "pwm_l6");
        push_pwm(1471, 1620, 7, "pwm_l7");

        // Down to 5, then safety stop mid-period.
        goto(1700);
        led = 7'b0011111;
        push(1702, SIG_TARGET, 5, "tgt_5");
        push(1820, SIG_LEVEL, 6, "dn_6");
        push(1960, SIG_LEVEL, 5, "dn_5");
        goto(2000);
        led = 7'b0000000;
        push(2002, SIG_LEVEL, 5, "stop_lvl_pre");
        push(2002, SIG_BUSY, 1, "stop_busy");
        push(2003, SIG_LEVEL, 0, "stop_lvl");
        push(2003, SIG_PWM, 1, "stop_pwm_pre");
        push(2003, SIG_BUSY, 0, "stop_busy_clr");
        push(2003, SIG_STATE, int'(IDLE), "stop_idle");
        push_pwm(2004, 2100, 0, "stop_pwm");

        // Reversal at level 4 after one counted boundary: spacing restarts.
        goto(2100);
        led = 7'b1111111;
        push(2102, SIG_TARGET, 7, "rev_tgt7");
        push(2240, SIG_LEVEL, 1, "rev_up1");
        push(2380, SIG_LEVEL, 2, "rev_up2");
        push(2520, SIG_LEVEL, 3, "rev_up3");
        push(2660, SIG_LEVEL, 4, "rev_up4");
        push_pwm(2661, 2730, 4, "pwm_l4");
        push(2741, SIG_RCNT, 1, "rev_rcnt_pre");
        goto(2740);
        led = 7'b0000011;
        push(2742, SIG_RCNT, 0, "rev_rcnt_clr");
        push(2742, SIG_TARGET, 2, "rev_tgt2");
        push(2800, SIG_LEVEL, 4, "rev_nostep");
        push(2869, SIG_LEVEL, 4, "rev_pre3");
        push(2870, SIG_LEVEL, 3, "rev_dn3");
        push(3009, SIG_LEVEL, 3, "rev_pre2");
        push(3010, SIG_LEVEL, 2, "rev_dn2");
        push(3010, SIG_STATE, int'(HOLD), "rev_hold");
        push(3010, SIG_BUSY, 0, "rev_busy");

        // Asynchronous reset mid-period at level 4.
        goto(3020);
        led = 7'b0001111;
        push(3022, SIG_TARGET, 4, "pre_rst_tgt");
        push(3150, SIG_LEVEL, 3, "pre_rst_3");
        push(3290, SIG_LEVEL, 4, "pre_rst_4");
        push(3300, SIG_PWM, 1, "pre_rst_pwm");
        goto(3300);
        #2;
        rst = 1'b1;
        #1;
        check("arst_pwm", pwm, 0);
        check("arst_level", level, 0);
        check("arst_busy", busy, 0);
        check("arst_fault", fault, 0);
        check("arst_tgt", dut.target_q, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push(2, SIG_TARGET, 4, "post_rst_tgt");
        push_pwm(1, 140, 0, "post_rst_pwm0");
        push(140, SIG_LEVEL, 1, "post_rst_lvl1");
        push_pwm(141, 150, 1, "post_rst_pwm1");

        goto(160);
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        check("sb_drain", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
